// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl -- multi-cycle sequencer for a MIPS-like datapath.
//
// Walks each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and
// drives the datapath control lines for the current step.
//
// Ports
//   cpu_clk      in   clock, all state changes on the rising edge
//   reset        in   synchronous active-high reset
//   inst         in   32-bit instruction word from the datapath
//   zero         in   ALU zero flag (branch resolution happens in the datapath)
//   overflow     in   ALU overflow flag, sampled in EXEC for add/sub/addi
//   mem_ready    in   data-memory acknowledge, only looked at in MEM
//   regJal .. BranchNeq  out  single-bit datapath controls
//   ALUControl   out  3-bit ALU operation select
//   PCSrc        out  next-PC select (00 pc+4, 10 jump target, 11 register)
//   pc_we        out  PC write enable, one cycle per finished/skipped instruction
//   mem_req      out  data-memory request, high for the whole MEM state
//   state        out  current sequencer state (FETCH=0 .. WB=4)
//   illegal      out  pulse: unsupported instruction skipped in DECODE
//   mem_timeout  out  pulse: memory did not answer within 16 MEM cycles
//   ovf_sticky   out  set when an overflowing result was not written back
//   retired      out  count of completed legal instructions
module cpu_seq_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic [31:0]       inst,
  input  logic              zero,
  input  logic              overflow,
  input  logic              mem_ready,
  output logic              regJal,
  output logic              ALUSrc1,
  output logic              ALUSrc2,
  output logic              RegWrite,
  output logic              RegDst,
  output logic              Mem2Reg,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              BranchEq,
  output logic              BranchNeq,
  output logic [2:0]        ALUControl,
  output logic [1:0]        PCSrc,
  output logic              pc_we,
  output logic              mem_req,
  output logic [2:0]        state,
  output logic              illegal,
  output logic              mem_timeout,
  output logic              ovf_sticky,
  output logic [DATA_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ILL   = 4'd0,
    C_ALU_R = 4'd1,
    C_ALU_I = 4'd2,
    C_JR    = 4'd3,
    C_BEQ   = 4'd4,
    C_BNE   = 4'd5,
    C_J     = 4'd6,
    C_JAL   = 4'd7,
    C_LW    = 4'd8,
    C_SW    = 4'd9
  } cls_t;

  typedef struct packed {
    cls_t       cls;
    logic [2:0] aluc;
    logic       src1;
    logic       src2;
    logic       regdst;
    logic       ovf_chk;
  } dec_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Opcode/funct decode. Anything not listed (including sll, funct 0x00)
  // comes back as C_ILL so DECODE skips it.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d = '0;
    d.cls = C_ILL;
    case (op)
      6'h00: begin
        d.cls    = C_ALU_R;
        d.regdst = 1'b1;
        case (fn)
          6'h20: begin d.aluc = ALU_ADD; d.ovf_chk = 1'b1; end
          6'h22: begin d.aluc = ALU_SUB; d.ovf_chk = 1'b1; end
          6'h24: d.aluc = ALU_AND;
          6'h25: d.aluc = ALU_OR;
          6'h26: d.aluc = ALU_XOR;
          6'h27: d.aluc = ALU_NOR;
          6'h2A: d.aluc = ALU_SLT;
          6'h02: begin d.aluc = ALU_SRL; d.src1 = 1'b1; end
          6'h08: d.cls = C_JR;
          default: begin d.cls = C_ILL; d.regdst = 1'b0; end
        endcase
      end
      6'h08: begin d.cls = C_ALU_I; d.aluc = ALU_ADD; d.src2 = 1'b1; d.ovf_chk = 1'b1; end
      6'h0C: begin d.cls = C_ALU_I; d.aluc = ALU_AND; d.src2 = 1'b1; end
      6'h0D: begin d.cls = C_ALU_I; d.aluc = ALU_OR;  d.src2 = 1'b1; end
      6'h0A: begin d.cls = C_ALU_I; d.aluc = ALU_SLT; d.src2 = 1'b1; end
      6'h23: begin d.cls = C_LW;    d.aluc = ALU_ADD; d.src2 = 1'b1; end
      6'h2B: begin d.cls = C_SW;    d.aluc = ALU_ADD; d.src2 = 1'b1; end
      6'h04: begin d.cls = C_BEQ;   d.aluc = ALU_SUB; end
      6'h05: begin d.cls = C_BNE;   d.aluc = ALU_SUB; end
      6'h02: d.cls = C_J;
      6'h03: d.cls = C_JAL;
      default: d.cls = C_ILL;
    endcase
    return d;
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              sticky_q, sticky_d;
  logic [DATA_W-1:0] retired_q;
  dec_t              dec_q, cur_dec;

  // Branch resolution and most instruction fields are consumed by the datapath.
  logic unused_bits;
  assign unused_bits = &{1'b0, zero, inst[25:6]};

  assign cur_dec    = decode(inst[31:26], inst[5:0]);
  assign state      = state_q;
  assign ovf_sticky = sticky_q;
  assign retired    = retired_q;

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= 4'd0;
      ovf_q     <= 1'b0;
      sticky_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      if (pc_we && !illegal && !mem_timeout)
        retired_q <= retired_q + {{(DATA_W-1){1'b0}}, 1'b1};
    end
  end

  // Decode is captured once in DECODE so EXEC/MEM/WB controls stay stable
  // even if the datapath lets inst wander; always reloaded before use.
  always_ff @(posedge cpu_clk) begin
    if (state_q == S_DECODE)
      dec_q <= cur_dec;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    sticky_d    = sticky_q;
    regJal      = 1'b0;
    ALUSrc1     = 1'b0;
    ALUSrc2     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    Mem2Reg     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    BranchEq    = 1'b0;
    BranchNeq   = 1'b0;
    ALUControl  = 3'b000;
    PCSrc       = 2'b00;
    pc_we       = 1'b0;
    mem_req     = 1'b0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;

    // Under reset every control stays low so an in-flight instruction
    // cannot commit anything on the reset cycle.
    if (reset) begin
      state_d = S_FETCH;
    end else begin
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
        ALUControl = dec_q.aluc;
        ALUSrc1    = dec_q.src1;
        ALUSrc2    = dec_q.src2;
        RegDst     = dec_q.regdst;
      end

      case (state_q)
        S_FETCH: state_d = S_DECODE;

        S_DECODE: begin
          if (cur_dec.cls == C_ILL) begin
            illegal = 1'b1;
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end

        S_EXEC: begin
          case (dec_q.cls)
            C_ALU_R, C_ALU_I: begin
              ovf_d   = dec_q.ovf_chk & overflow;
              state_d = S_WB;
            end
            C_BEQ: begin BranchEq  = 1'b1; pc_we = 1'b1; state_d = S_FETCH; end
            C_BNE: begin BranchNeq = 1'b1; pc_we = 1'b1; state_d = S_FETCH; end
            C_J:   begin PCSrc = 2'b10; pc_we = 1'b1; state_d = S_FETCH; end
            C_JR:  begin PCSrc = 2'b11; pc_we = 1'b1; state_d = S_FETCH; end
            C_JAL: state_d = S_WB;
            C_LW, C_SW: begin
              cnt_d   = 4'd0;
              state_d = S_MEM;
            end
            default: state_d = S_FETCH;
          endcase
        end

        S_MEM: begin
          mem_req  = 1'b1;
          MemRead  = (dec_q.cls == C_LW);
          MemWrite = (dec_q.cls == C_SW);
          // An acknowledge on the 16th cycle still wins over the timeout.
          if (mem_ready) begin
            if (dec_q.cls == C_SW) begin
              pc_we   = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (cnt_q == 4'd15) begin
            mem_timeout = 1'b1;
            pc_we       = 1'b1;
            state_d     = S_FETCH;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end

        S_WB: begin
          pc_we   = 1'b1;
          state_d = S_FETCH;
          case (dec_q.cls)
            C_LW: begin
              Mem2Reg  = 1'b1;
              RegWrite = 1'b1;
            end
            C_JAL: begin
              regJal   = 1'b1;
              RegWrite = 1'b1;
              PCSrc    = 2'b10;
            end
            default: begin
              // An overflowing add/sub/addi is dropped and remembered.
              RegWrite = ~ovf_q;
              if (ovf_q) sticky_d = 1'b1;
            end
          endcase
        end

        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl -- scoreboard bench for cpu_seq_ctrl.
// Each test queues per-cycle stimulus together with the expected state,
// control vector, retired count and sticky flag; the runner pops entries,
// applies the stimulus after the rising edge and compares on the falling edge.
module tb_cpu_seq_ctrl;

  logic        cpu_clk = 1'b0;
  logic        reset, zero, overflow, mem_ready;
  logic [31:0] inst;
  logic        regJal, ALUSrc1, ALUSrc2, RegWrite, RegDst, Mem2Reg;
  logic        MemRead, MemWrite, BranchEq, BranchNeq, pc_we, mem_req;
  logic        illegal, mem_timeout, ovf_sticky;
  logic [2:0]  ALUControl, state;
  logic [1:0]  PCSrc;
  logic [31:0] retired;

  always #5 cpu_clk = ~cpu_clk;

  cpu_seq_ctrl #(.DATA_W(32)) dut (
    .cpu_clk(cpu_clk), .reset(reset), .inst(inst), .zero(zero),
    .overflow(overflow), .mem_ready(mem_ready), .regJal(regJal),
    .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .RegWrite(RegWrite),
    .RegDst(RegDst), .Mem2Reg(Mem2Reg), .MemRead(MemRead),
    .MemWrite(MemWrite), .BranchEq(BranchEq), .BranchNeq(BranchNeq),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .pc_we(pc_we),
    .mem_req(mem_req), .state(state), .illegal(illegal),
    .mem_timeout(mem_timeout), .ovf_sticky(ovf_sticky), .retired(retired)
  );

  // Control vector layout, MSB first.
  logic [18:0] ctl_obs;
  assign ctl_obs = {regJal, ALUSrc1, ALUSrc2, RegWrite, RegDst, Mem2Reg,
                    MemRead, MemWrite, BranchEq, BranchNeq, ALUControl,
                    PCSrc, pc_we, mem_req, illegal, mem_timeout};

  localparam logic [18:0] RJ   = 19'h1 << 18;
  localparam logic [18:0] S1   = 19'h1 << 17;
  localparam logic [18:0] S2   = 19'h1 << 16;
  localparam logic [18:0] RW   = 19'h1 << 15;
  localparam logic [18:0] RD   = 19'h1 << 14;
  localparam logic [18:0] M2R  = 19'h1 << 13;
  localparam logic [18:0] MRD  = 19'h1 << 12;
  localparam logic [18:0] MWR  = 19'h1 << 11;
  localparam logic [18:0] B_EQ = 19'h1 << 10;
  localparam logic [18:0] B_NE = 19'h1 << 9;
  localparam logic [18:0] PCWE = 19'h1 << 3;
  localparam logic [18:0] MREQ = 19'h1 << 2;
  localparam logic [18:0] ILL  = 19'h1 << 1;
  localparam logic [18:0] TO   = 19'h1;

  function automatic logic [18:0] ac(input logic [2:0] a);
    return {10'b0, a, 6'b0};
  endfunction
  function automatic logic [18:0] ps(input logic [1:0] p);
    return {13'b0, p, 4'b0};
  endfunction

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_LW   = 32'h8C22_0004;
  localparam logic [31:0] I_SW   = 32'hAC22_0008;
  localparam logic [31:0] I_BEQ  = 32'h1021_0002;
  localparam logic [31:0] I_BNE  = 32'h1422_0003;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_JR   = 32'h03E0_0008;
  localparam logic [31:0] I_ADDI = 32'h2022_0005;
  localparam logic [31:0] I_SRL  = 32'h0002_1082;
  localparam logic [31:0] I_SLL  = 32'h0002_1080;
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;

  typedef struct {
    logic        rst;
    logic [31:0] in;
    logic        z, o, mr;
    logic [2:0]  st;
    logic [18:0] ctl;
    logic [31:0] ret;
    logic        stk;
  } rec_t;

  rec_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input logic rst, input logic [31:0] in, input logic z,
                      input logic o, input logic mr, input logic [2:0] st,
                      input logic [18:0] ctl, input logic [31:0] ret,
                      input logic stk);
    rec_t r;
    r.rst = rst; r.in = in; r.z = z; r.o = o; r.mr = mr;
    r.st = st; r.ctl = ctl; r.ret = ret; r.stk = stk;
    sb.push_back(r);
  endtask

  // FETCH and DECODE cycles of a legal instruction: no controls active.
  task automatic push_fd(input logic [31:0] in, input logic [31:0] ret,
                         input logic stk);
    push(0, in, 0, 0, 0, 3'd0, '0, ret, stk);
    push(0, in, 0, 0, 0, 3'd1, '0, ret, stk);
  endtask

  task automatic run_sb();
    rec_t r;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      reset = r.rst; inst = r.in; zero = r.z; overflow = r.o; mem_ready = r.mr;
      @(negedge cpu_clk);
      check_val("state", {29'b0, state}, {29'b0, r.st});
      check_val("ctl", {13'b0, ctl_obs}, {13'b0, r.ctl});
      check_val("retired", retired, r.ret);
      check_val("ovf_sticky", {31'b0, ovf_sticky}, {31'b0, r.stk});
      @(posedge cpu_clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    reset = 1'b1; inst = '0; zero = 1'b0; overflow = 1'b0; mem_ready = 1'b0;
    @(posedge cpu_clk);
    #1;

    // Held in reset: FETCH, everything low.
    push(1, I_ADD, 0, 0, 0, 3'd0, '0, 0, 0);

    // add $3,$1,$2
    push_fd(I_ADD, 0, 0);
    push(0, I_ADD, 0, 0, 0, 3'd2, RD | ac(3'b010), 0, 0);
    push(0, I_ADD, 0, 0, 0, 3'd4, RW | RD | ac(3'b010) | PCWE, 0, 0);

    // lw, ready on the third MEM cycle
    push_fd(I_LW, 1, 0);
    push(0, I_LW, 0, 0, 0, 3'd2, S2 | ac(3'b010), 1, 0);
    push(0, I_LW, 0, 0, 0, 3'd3, S2 | ac(3'b010) | MRD | MREQ, 1, 0);
    push(0, I_LW, 0, 0, 0, 3'd3, S2 | ac(3'b010) | MRD | MREQ, 1, 0);
    push(0, I_LW, 0, 0, 1, 3'd3, S2 | ac(3'b010) | MRD | MREQ, 1, 0);
    push(0, I_LW, 0, 0, 0, 3'd4, S2 | ac(3'b010) | M2R | RW | PCWE, 1, 0);

    // sw, memory never answers: 16 MEM cycles then timeout
    push_fd(I_SW, 2, 0);
    push(0, I_SW, 0, 0, 0, 3'd2, S2 | ac(3'b010), 2, 0);
    for (int i = 0; i < 15; i++)
      push(0, I_SW, 0, 0, 0, 3'd3, S2 | ac(3'b010) | MWR | MREQ, 2, 0);
    push(0, I_SW, 0, 0, 0, 3'd3, S2 | ac(3'b010) | MWR | MREQ | PCWE | TO, 2, 0);

    // beq with zero=1
    push_fd(I_BEQ, 2, 0);
    push(0, I_BEQ, 1, 0, 0, 3'd2, B_EQ | ac(3'b110) | PCWE, 2, 0);

    // jal
    push_fd(I_JAL, 3, 0);
    push(0, I_JAL, 0, 0, 0, 3'd2, '0, 3, 0);
    push(0, I_JAL, 0, 0, 0, 3'd4, RJ | RW | ps(2'b10) | PCWE, 3, 0);

    // addi overflowing: write suppressed, sticky set afterwards
    push_fd(I_ADDI, 4, 0);
    push(0, I_ADDI, 0, 1, 0, 3'd2, S2 | ac(3'b010), 4, 0);
    push(0, I_ADDI, 0, 0, 0, 3'd4, S2 | ac(3'b010) | PCWE, 4, 0);

    // opcode 0x3F and sll are skipped in DECODE without counting
    push(0, I_BAD, 0, 0, 0, 3'd0, '0, 5, 1);
    push(0, I_BAD, 0, 0, 0, 3'd1, ILL | PCWE, 5, 1);
    push(0, I_SLL, 0, 0, 0, 3'd0, '0, 5, 1);
    push(0, I_SLL, 0, 0, 0, 3'd1, ILL | PCWE, 5, 1);

    // j and jr
    push_fd(I_J, 5, 1);
    push(0, I_J, 0, 0, 0, 3'd2, ps(2'b10) | PCWE, 5, 1);
    push_fd(I_JR, 6, 1);
    push(0, I_JR, 0, 0, 0, 3'd2, RD | ps(2'b11) | PCWE, 6, 1);

    // srl ignores overflow
    push_fd(I_SRL, 7, 1);
    push(0, I_SRL, 0, 1, 0, 3'd2, S1 | RD | ac(3'b101), 7, 1);
    push(0, I_SRL, 0, 0, 0, 3'd4, S1 | RD | ac(3'b101) | RW | PCWE, 7, 1);

    // bne with zero=0
    push_fd(I_BNE, 8, 1);
    push(0, I_BNE, 0, 0, 0, 3'd2, B_NE | ac(3'b110) | PCWE, 8, 1);

    // lw abandoned by reset in MEM
    push_fd(I_LW, 9, 1);
    push(0, I_LW, 0, 0, 0, 3'd2, S2 | ac(3'b010), 9, 1);
    push(0, I_LW, 0, 0, 0, 3'd3, S2 | ac(3'b010) | MRD | MREQ, 9, 1);
    push(1, I_LW, 0, 0, 1, 3'd3, '0, 9, 1);
    push(0, I_ADD, 0, 0, 0, 3'd0, '0, 0, 0);

    // add after reset counts from zero again
    push(0, I_ADD, 0, 0, 0, 3'd1, '0, 0, 0);
    push(0, I_ADD, 0, 0, 0, 3'd2, RD | ac(3'b010), 0, 0);
    push(0, I_ADD, 0, 0, 0, 3'd4, RW | RD | ac(3'b010) | PCWE, 0, 0);
    push(0, I_ADD, 0, 0, 0, 3'd0, '0, 1, 0);

    run_sb();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
